bus_rr_arbiter: RTL and testbench

BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

---
 rtl/bus_rr_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_bus_rr_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: shared-bus arbiter that moves one packet at a time from
// DRVRS driver FIFOs to DRVRS receiver FIFOs. It routes each packet by a
// destination ID held in the packet MSBs and supports broadcast.
// Optional build macro BUS_RR_ARB_CNT_EN adds per-driver saturating counters
// of successful pushes on output grant_cnt.
module bus_rr_arbiter #(
  parameter int              DRVRS     = 4,
  parameter int              PCKG_SZ   = 16,
  parameter int              ID_W      = 8,
  parameter logic [ID_W-1:0] BROADCAST = {ID_W{1'b1}},
  parameter int              MODE      = 0,
  parameter int              TIMEOUT   = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DRVRS-1:0]           pndng,
  input  logic [DRVRS*PCKG_SZ-1:0]   D_pop,
  input  logic [DRVRS-1:0]           full,
  output logic [DRVRS-1:0]           pop,
  output logic [DRVRS-1:0]           push,
  output logic [PCKG_SZ-1:0]         D_push,
  output logic [$clog2(DRVRS)-1:0]   grant_id,
  output logic                       busy,
  output logic                       err
`ifdef BUS_RR_ARB_CNT_EN
  ,
  output logic [DRVRS*16-1:0]        grant_cnt
`endif
);

  localparam int GW = $clog2(DRVRS);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ARB, SEND} state_t;

  state_t               state_q, state_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [GW-1:0]        last_q, last_d;
  logic [DRVRS-1:0]     pop_q, pop_d;
  logic [DRVRS-1:0]     push_q, push_d;
  logic [PCKG_SZ-1:0]   dpush_q, dpush_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic [CW-1:0]        stall_q, stall_d;

  logic [GW-1:0]        winner;
  logic [DRVRS-1:0]     grant_oh;
  logic [DRVRS-1:0]     tgt_mask;
  logic [ID_W-1:0]      dest;
  logic                 is_bcast;
  logic                 dest_ok;

  // Destination decode works on the latched packet so it is stable through SEND.
  assign dest     = dpush_q[PCKG_SZ-1 -: ID_W];
  assign is_bcast = (dest == BROADCAST);
  assign dest_ok  = is_bcast ||
                    ((32'(dest) < 32'(DRVRS)) && (32'(dest) != 32'(grant_q)));

  for (genvar gi = 0; gi < DRVRS; gi++) begin : g_mask
    assign grant_oh[gi] = (grant_q == GW'(gi));
    assign tgt_mask[gi] = is_bcast ? !grant_oh[gi]
                                   : (dest_ok && (32'(dest) == gi));
  end

  // Winner search: fixed priority scans from 0, round-robin scans after last_grant.
  always_comb begin
    int  idx;
    logic found;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    if (MODE == 1) begin
      for (int k = 0; k < DRVRS; k++) begin
        if (!found && pndng[k]) begin
          winner = GW'(k);
          found  = 1'b1;
        end
      end
    end else begin
      for (int k = 1; k <= DRVRS; k++) begin
        idx = (int'(last_q) + k) % DRVRS;
        if (!found && pndng[idx]) begin
          winner = GW'(idx);
          found  = 1'b1;
        end
      end
    end
  end

  // Next-state and next-output logic for the IDLE/ARB/SEND sequence.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    pop_d   = '0;
    push_d  = '0;
    dpush_d = dpush_q;
    err_d   = 1'b0;
    stall_d = stall_q;
    case (state_q)
      IDLE: begin
        if (|pndng) begin
          grant_d = winner;
          if (MODE == 0) last_d = winner;
          state_d = ARB;
        end
      end
      ARB: begin
        // The driver may have withdrawn its request; only pop if still pending.
        if (pndng[grant_q]) begin
          pop_d   = grant_oh;
          dpush_d = D_pop[grant_q*PCKG_SZ +: PCKG_SZ];
          stall_d = '0;
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (!dest_ok) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if ((tgt_mask & full) == '0) begin
          // All targets must be ready together so a broadcast is never partial.
          push_d  = tgt_mask;
          state_d = IDLE;
        end else if (stall_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          stall_d = stall_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs; reset drops any latched packet.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(DRVRS - 1);
      pop_q   <= '0;
      push_q  <= '0;
      dpush_q <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      pop_q   <= pop_d;
      push_q  <= push_d;
      dpush_q <= dpush_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end

  assign pop      = pop_q;
  assign push     = push_q;
  assign D_push   = dpush_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;
  assign err      = err_q;

`ifdef BUS_RR_ARB_CNT_EN
  for (genvar gi = 0; gi < DRVRS; gi++) begin : g_cnt
    logic [15:0] cnt_q, cnt_d;

    // Count a successful push for the owning driver, saturating at all-ones.
    always_comb begin
      cnt_d = cnt_q;
      if ((state_q == SEND) && (push_d != '0) && grant_oh[gi] && (cnt_q != 16'hFFFF))
        cnt_d = cnt_q + 16'd1;
    end

    // Counter register cleared by reset.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end

    assign grant_cnt[gi*16 +: 16] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Directed testbench for bus_rr_arbiter: one round-robin instance and one
// fixed-priority instance share the same stimulus.
module tb_bus_rr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  pndng;
  logic [3:0]  full;
  logic [63:0] d_pop;
  logic [3:0]  pop, push, pop_f, push_f;
  logic [15:0] d_push, d_push_f;
  logic [1:0]  gid, gid_f;
  logic        busy, err, busy_f, err_f;

  int checks   = 0;
  int failures = 0;
  int c        = 0;
  logic [15:0] pk [4];
  logic [3:0]  ep, eu;
  int          g;

  always #5 clk = ~clk;

  bus_rr_arbiter #(.MODE(0)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(d_pop), .full(full),
    .pop(pop), .push(push), .D_push(d_push), .grant_id(gid),
    .busy(busy), .err(err)
  );

  bus_rr_arbiter #(.MODE(1)) dut_fp (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(d_pop), .full(full),
    .pop(pop_f), .push(push_f), .D_push(d_push_f), .grant_id(gid_f),
    .busy(busy_f), .err(err_f)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    c++;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    c = 0;
  endtask

  task automatic set_pkt(input int i, input logic [15:0] v);
    d_pop[i*16 +: 16] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pndng = '0; full = '0; d_pop = '0;
    #2 reset = 1'b0;
    #1;
    chk("rst_pop", 32'(pop), 0);
    chk("rst_push", 32'(push), 0);
    chk("rst_dpush", 32'(d_push), 0);
    chk("rst_gid", 32'(gid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);
    $display("reset state checked");

    // Round-robin with all drivers pending: order 0,1,2,3,0.
    pk[0] = 16'h01A0; pk[1] = 16'h02A1; pk[2] = 16'h03A2; pk[3] = 16'h00A3;
    for (int i = 0; i < 4; i++) set_pkt(i, pk[i]);
    pndng = 4'b1111;
    do_reset();
    for (int k = 0; k < 15; k++) begin
      step();
      ep = '0; eu = '0;
      if (c % 3 == 2) begin
        g  = ((c - 2) / 3) % 4;
        ep = 4'b0001 << g;
        chk("rr_gid", 32'(gid), 32'(g));
      end
      if (c % 3 == 0) begin
        g  = ((c - 3) / 3) % 4;
        eu = 4'b0001 << ((g + 1) % 4);
        chk("rr_dpush", 32'(d_push), 32'(pk[g]));
      end
      chk("rr_pop", 32'(pop), 32'(ep));
      chk("rr_push", 32'(push), 32'(eu));
      chk("rr_excl", 32'(pop & push), 0);
      $display("rr cycle %0d pop=%b push=%b gid=%0d", c, pop, push, gid);
    end
    pndng = '0;

    // Drivers 1 and 3 pending: fixed priority always picks 1, round-robin alternates.
    set_pkt(1, 16'h0011); set_pkt(3, 16'h0033);
    pndng = 4'b1010;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      step();
      if (c % 3 == 2) begin
        chk("fp_pop", 32'(pop_f), 32'(4'b0010));
        chk("fp_gid", 32'(gid_f), 1);
        chk("rr13_pop", 32'(pop), (((c - 2) / 3) % 2 == 0) ? 32'(4'b0010) : 32'(4'b1000));
      end else begin
        chk("fp_pop_idle", 32'(pop_f), 0);
      end
      $display("fp cycle %0d pop_f=%b pop=%b", c, pop_f, pop);
    end
    pndng = '0;

    // Broadcast from driver 2.
    set_pkt(2, 16'hFF5A);
    pndng = 4'b0100;
    do_reset();
    step(); step();
    chk("bc_pop", 32'(pop), 32'(4'b0100));
    pndng = '0;
    step();
    chk("bc_push", 32'(push), 32'(4'b1011));
    chk("bc_dpush", 32'(d_push), 32'h0000FF5A);
    chk("bc_err", 32'(err), 0);
    step();
    chk("bc_push_once", 32'(push), 0);
    chk("bc_hold", 32'(d_push), 32'h0000FF5A);
    chk("bc_busy", 32'(busy), 0);
    $display("broadcast transaction done");

    // Stall for 10 cycles on full[1], then release.
    set_pkt(0, 16'h0133);
    full = 4'b0010; pndng = 4'b0001;
    do_reset();
    step(); step();
    chk("st_pop", 32'(pop), 32'(4'b0001));
    pndng = '0;
    repeat (10) step();
    chk("st_push_held", 32'(push), 0);
    chk("st_busy", 32'(busy), 1);
    full = '0;
    step();
    chk("st_push", 32'(push), 32'(4'b0010));
    chk("st_dpush", 32'(d_push), 32'h00000133);
    chk("st_err", 32'(err), 0);
    step();
    chk("st_push_once", 32'(push), 0);
    $display("stall-then-release transaction done");

    // Stall held: drop on the 64th stalled cycle.
    full = 4'b0010; pndng = 4'b0001;
    do_reset();
    step(); step();
    pndng = '0;
    while (c < 70) begin
      step();
      chk("to_err", 32'(err), (c == 66) ? 1 : 0);
      chk("to_push", 32'(push), 0);
      if (c == 66) chk("to_busy", 32'(busy), 0);
    end
    full = '0;
    $display("timeout transaction done");

    // Invalid destinations: self and out of range.
    for (int t = 0; t < 2; t++) begin
      set_pkt(1, (t == 0) ? 16'h0111 : 16'h0722);
      pndng = 4'b0010;
      do_reset();
      step(); step();
      chk("bad_pop", 32'(pop), 32'(4'b0010));
      pndng = '0;
      step();
      chk("bad_err", 32'(err), 1);
      chk("bad_push", 32'(push), 0);
      chk("bad_busy", 32'(busy), 0);
      step();
      chk("bad_err_once", 32'(err), 0);
      chk("bad_push2", 32'(push), 0);
      $display("invalid dest %0d transaction done", t);
    end

    // Reset during SEND discards the packet; driver 1 wins first afterwards.
    set_pkt(0, 16'h0133);
    full = 4'b0010; pndng = 4'b0001;
    do_reset();
    repeat (4) step();
    chk("mr_busy_pre", 32'(busy), 1);
    reset = 1'b0;
    #1;
    chk("mr_pop", 32'(pop), 0);
    chk("mr_push", 32'(push), 0);
    chk("mr_dpush", 32'(d_push), 0);
    chk("mr_gid", 32'(gid), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_err", 32'(err), 0);
    set_pkt(1, 16'h0077);
    pndng = 4'b0110; full = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    c = 0;
    step(); step();
    chk("mr_pop1", 32'(pop), 32'(4'b0010));
    chk("mr_gid1", 32'(gid), 1);
    pndng = '0;
    step();
    chk("mr_push1", 32'(push), 32'(4'b0001));
    chk("mr_dpush1", 32'(d_push), 32'h00000077);
    $display("mid-transfer reset transaction done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
